// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH glitch-free programmable clock dividers with shadowed divide values
// Ports: int_clk/rst_n (async active-low) clock and reset; ch_en per-channel run enable;
//   cfg_wr/cfg_ch/cfg_div write a new divide value into a channel's shadow; cfg_ack one cycle later;
//   div_clk_o divided clocks, period 2*(div+1); pend_o shadow-waiting flags;
//   tick_o rising-edge pulses, present only when CLK_DIV_TICK_EN is defined.
module clk_div_bank #(
  parameter int NCH = 4,
  parameter int DW = 8,
  parameter int DIV_RST = 3,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           int_clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] ch_en,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  output logic           cfg_ack,
  output logic [NCH-1:0] div_clk_o,
  output logic [NCH-1:0] pend_o
`ifdef CLK_DIV_TICK_EN
  ,
  output logic [NCH-1:0] tick_o
`endif
);
  always_ff @(posedge int_clk or negedge rst_n)
    if (!rst_n) cfg_ack <= 1'b0;
    else cfg_ack <= cfg_wr;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] cnt, div_a, div_s;
    logic q, pend, run, hit, bnd, wr_hit;
    // a disabled channel keeps running until its high phase ends, so no runt pulse
    assign run = ch_en[i] | q;
    assign hit = run && cnt == div_a;
    // boundary: the falling toggle, or any cycle spent parked low
    assign bnd = (hit && q) || (!ch_en[i] && !q);
    // out-of-range channel numbers never match any channel, so they only ack
    assign wr_hit = cfg_wr && cfg_ch == CHW'(i);
    always_ff @(posedge int_clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        q <= 1'b0;
        div_a <= DW'(DIV_RST);
        div_s <= DW'(DIV_RST);
        pend <= 1'b0;
      end else begin
        cnt <= (hit || !run) ? '0 : cnt + 1'b1;
        q <= q ^ hit;
        // a write landing on a boundary lets the old shadow load and keeps pend for the new one
        div_a <= (bnd && pend) ? div_s : div_a;
        div_s <= wr_hit ? cfg_div : div_s;
        pend <= wr_hit || (pend && !bnd);
      end
    assign div_clk_o[i] = q;
    assign pend_o[i] = pend;
`ifdef CLK_DIV_TICK_EN
    logic tk;
    always_ff @(posedge int_clk or negedge rst_n)
      if (!rst_n) tk <= 1'b0;
      else tk <= hit && !q;
    assign tick_o[i] = tk;
`endif
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed table-driven bench for clk_div_bank plus multi-cycle corner sequences
module tb_clk_div_bank;
  logic int_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] ch_en = '0;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic cfg_ack;
  logic [3:0] div_clk, pend;
  logic [5:0] ch_en6 = 6'h3f;
  logic cfg_wr6 = 1'b0;
  logic [2:0] cfg_ch6 = '0;
  logic [7:0] cfg_div6 = '0;
  logic ack6;
  logic [5:0] clk6, pend6;
`ifdef CLK_DIV_TICK_EN
  logic [3:0] tick;
  logic [5:0] tick6;
`endif
  int nvec = 0;
  int nmis = 0;

  always #5 int_clk = ~int_clk;

  clk_div_bank u_dut (
    .int_clk(int_clk), .rst_n(rst_n), .ch_en(ch_en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ack(cfg_ack), .div_clk_o(div_clk), .pend_o(pend)
`ifdef CLK_DIV_TICK_EN
    , .tick_o(tick)
`endif
  );

  clk_div_bank #(.NCH(6)) u_six (
    .int_clk(int_clk), .rst_n(rst_n), .ch_en(ch_en6), .cfg_wr(cfg_wr6), .cfg_ch(cfg_ch6),
    .cfg_div(cfg_div6), .cfg_ack(ack6), .div_clk_o(clk6), .pend_o(pend6)
`ifdef CLK_DIV_TICK_EN
    , .tick_o(tick6)
`endif
  );

  typedef struct {
    logic [3:0] en;
    logic wr;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [3:0] clk;
    logic [3:0] pnd;
    logic ack;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] en, input logic wr, input logic [1:0] ch, input logic [7:0] dv,
                     input logic [3:0] c, input logic [3:0] p, input logic a);
    vec_t v;
    v.en = en; v.wr = wr; v.ch = ch; v.dv = dv; v.clk = c; v.pnd = p; v.ack = a;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic rise6(output int n);
    logic p;
    bit done;
    n = 0;
    done = 0;
    p = clk6[0];
    while (!done) begin
      @(posedge int_clk); #1;
      n++;
      done = (clk6[0] && !p) || n >= 40;
      p = clk6[0];
    end
  endtask

  initial begin
    int n;
    logic [3:0] prev;
    // startup at default divide 3, then ch1 -> div 0 written mid high phase
    add(4'hf,0,0,0, 4'h0,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0);
    add(4'hf,0,0,0, 4'hf,4'h0,0); add(4'hf,0,0,0, 4'hf,4'h0,0); add(4'hf,0,0,0, 4'hf,4'h0,0);
    add(4'hf,0,0,0, 4'hf,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0);
    add(4'hf,0,0,0, 4'h0,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0); add(4'hf,0,0,0, 4'hf,4'h0,0);
    add(4'hf,1,1,0, 4'hf,4'h2,1); add(4'hf,0,0,0, 4'hf,4'h2,0); add(4'hf,0,0,0, 4'hf,4'h2,0);
    add(4'hf,0,0,0, 4'h0,4'h0,0); add(4'hf,0,0,0, 4'h2,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0);
    add(4'hf,0,0,0, 4'h2,4'h0,0); add(4'hf,0,0,0, 4'hd,4'h0,0); add(4'hf,0,0,0, 4'hf,4'h0,0);
    add(4'hf,0,0,0, 4'hd,4'h0,0); add(4'hf,0,0,0, 4'hf,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0);
    add(4'hf,0,0,0, 4'h2,4'h0,0); add(4'hf,0,0,0, 4'h0,4'h0,0); add(4'hf,0,0,0, 4'h2,4'h0,0);
    add(4'hf,0,0,0, 4'hd,4'h0,0);
    // ch2 disabled one cycle into its high phase, then re-enabled
    add(4'hb,0,0,0, 4'hf,4'h0,0); add(4'hb,0,0,0, 4'hd,4'h0,0); add(4'hb,0,0,0, 4'hf,4'h0,0);
    add(4'hb,0,0,0, 4'h0,4'h0,0); add(4'hb,0,0,0, 4'h2,4'h0,0); add(4'hb,0,0,0, 4'h0,4'h0,0);
    add(4'hb,0,0,0, 4'h2,4'h0,0); add(4'hb,0,0,0, 4'h9,4'h0,0);
    add(4'hf,0,0,0, 4'hb,4'h0,0); add(4'hf,0,0,0, 4'h9,4'h0,0); add(4'hf,0,0,0, 4'hb,4'h0,0);
    add(4'hf,0,0,0, 4'h4,4'h0,0);
    // two writes to ch0 within one period: only div 1 applies
    add(4'hf,1,0,5, 4'h6,4'h1,1); add(4'hf,1,0,1, 4'h4,4'h1,1); add(4'hf,0,0,0, 4'h6,4'h1,0);
    add(4'hf,0,0,0, 4'h9,4'h1,0); add(4'hf,0,0,0, 4'hb,4'h1,0); add(4'hf,0,0,0, 4'h9,4'h1,0);
    add(4'hf,0,0,0, 4'hb,4'h1,0); add(4'hf,0,0,0, 4'h4,4'h0,0); add(4'hf,0,0,0, 4'h6,4'h0,0);
    add(4'hf,0,0,0, 4'h5,4'h0,0); add(4'hf,0,0,0, 4'h7,4'h0,0); add(4'hf,0,0,0, 4'h8,4'h0,0);
    add(4'hf,0,0,0, 4'ha,4'h0,0); add(4'hf,0,0,0, 4'h9,4'h0,0);
    // ch3: pending div 0, then div 1 written exactly on the falling boundary
    add(4'hf,1,3,0, 4'hb,4'h8,1); add(4'hf,1,3,1, 4'h4,4'h8,1); add(4'hf,0,0,0, 4'he,4'h8,0);
    add(4'hf,0,0,0, 4'h5,4'h0,0); add(4'hf,0,0,0, 4'h7,4'h0,0); add(4'hf,0,0,0, 4'h8,4'h0,0);
    add(4'hf,0,0,0, 4'ha,4'h0,0); add(4'hf,0,0,0, 4'h1,4'h0,0);

    repeat (2) @(posedge int_clk);
    #1;
    check("reset div_clk", 32'(div_clk), 32'h0);
    check("reset pend", 32'(pend), 32'h0);
    check("reset ack", 32'(cfg_ack), 32'h0);
`ifdef CLK_DIV_TICK_EN
    check("reset tick", 32'(tick), 32'h0);
`endif
    @(negedge int_clk) rst_n = 1'b1;
    prev = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      ch_en = tbl[i].en; cfg_wr = tbl[i].wr; cfg_ch = tbl[i].ch; cfg_div = tbl[i].dv;
      @(posedge int_clk); #1;
      check($sformatf("row%0d div_clk", i + 1), 32'(div_clk), 32'(tbl[i].clk));
      check($sformatf("row%0d pend", i + 1), 32'(pend), 32'(tbl[i].pnd));
      check($sformatf("row%0d ack", i + 1), 32'(cfg_ack), 32'(tbl[i].ack));
`ifdef CLK_DIV_TICK_EN
      check($sformatf("row%0d tick", i + 1), 32'(tick), 32'(tbl[i].clk & ~prev));
`endif
      prev = tbl[i].clk;
    end
    cfg_wr = 1'b0;

    // NCH=6 instance: out-of-range writes ack but change nothing
    cfg_wr6 = 1'b1; cfg_ch6 = 3'd7; cfg_div6 = 8'd0;
    @(posedge int_clk); #1;
    cfg_wr6 = 1'b0;
    check("oor7 ack", 32'(ack6), 32'h1);
    check("oor7 pend", 32'(pend6), 32'h0);
    cfg_wr6 = 1'b1; cfg_ch6 = 3'd6;
    @(posedge int_clk); #1;
    cfg_wr6 = 1'b0;
    check("oor6 ack", 32'(ack6), 32'h1);
    check("oor6 pend", 32'(pend6), 32'h0);
    @(posedge int_clk); #1;
    check("oor ack one-shot", 32'(ack6), 32'h0);
    rise6(n);
    rise6(n);
    check("oor ch0 period", 32'(n), 32'd8);
    check("oor pend after", 32'(pend6), 32'h0);
    cfg_wr6 = 1'b1; cfg_ch6 = 3'd5;
    @(posedge int_clk); #1;
    cfg_wr6 = 1'b0;
    check("ch5 ack", 32'(ack6), 32'h1);
    check("ch5 pend", 32'(pend6), 32'h20);

    // reset mid-period discards a pending write
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7;
    @(posedge int_clk); #1;
    cfg_wr = 1'b0;
    check("pre-reset pend", 32'(pend[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset div_clk", 32'(div_clk), 32'h0);
    check("async reset pend", 32'(pend), 32'h0);
    check("async reset ack", 32'(cfg_ack), 32'h0);
    @(negedge int_clk) rst_n = 1'b1;
    n = 0;
    while (div_clk !== 4'hf && n < 20) begin @(posedge int_clk); #1; n++; end
    check("post-reset first rise", 32'(n), 32'd4);
    n = 0;
    while (div_clk[0] !== 1'b0 && n < 20) begin @(posedge int_clk); #1; n++; end
    check("post-reset high", 32'(n), 32'd4);
    n = 0;
    while (div_clk[0] !== 1'b1 && n < 20) begin @(posedge int_clk); #1; n++; end
    check("post-reset low", 32'(n), 32'd4);
    check("post-reset pend", 32'(pend), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
